// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: holds one decoded instruction, selects operands
// with writeback bypass, and inserts one bubble on a load-use dependency.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  input  logic [3:0]  in_alu_op,
  input  logic        in_alu_src,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_reg_write,
  input  logic [31:0] rf_data1,
  input  logic [31:0] rf_data2,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rd,
  output logic [3:0]  out_alu_op,
  output logic        out_alu_src,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        out_reg_write,
  output logic [15:0] stall_count
);

  logic        valid_r;
  logic [31:0] pc_r, op1_r, op2_r, imm_r;
  logic [4:0]  rd_r;
  logic [3:0]  alu_op_r;
  logic        alu_src_r, mem_read_r, mem_write_r, reg_write_r;
  logic [15:0] stall_cnt_r;
  logic        hazard_s, ready_s, accept_s;
  logic [31:0] op1_s, op2_s;

  // x0 wins over bypass, so a writeback to x0 can never leak a value
  function automatic logic [31:0] sel_operand(
    input logic [4:0]  rs,
    input logic [31:0] rf,
    input logic        wb_we,
    input logic [4:0]  wb_addr,
    input logic [31:0] wb_val
  );
    if (rs == 5'd0) begin
      return 32'd0;
    end else if (wb_we && (wb_addr == rs)) begin
      return wb_val;
    end else begin
      return rf;
    end
  endfunction

  // Load-use hazard detection, handshake and operand selection
  always_comb begin
    hazard_s = valid_r && mem_read_r && (rd_r != 5'd0) && in_valid &&
               ((in_rs1 == rd_r) || (in_rs2 == rd_r));
    if (!rst_n) begin
      ready_s = 1'b0;
    end else if (flush) begin
      ready_s = 1'b1;
    end else begin
      ready_s = (!valid_r || out_ready) && !hazard_s;
    end
    accept_s = in_valid && ready_s;
    op1_s = sel_operand(in_rs1, rf_data1, wb_regwrite, wb_rd, wb_data);
    op2_s = sel_operand(in_rs2, rf_data2, wb_regwrite, wb_rd, wb_data);
  end

  // Pipeline register; side-effect controls are cleared whenever valid drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r     <= 1'b0;
      pc_r        <= 32'd0;
      op1_r       <= 32'd0;
      op2_r       <= 32'd0;
      imm_r       <= 32'd0;
      rd_r        <= 5'd0;
      alu_op_r    <= 4'd0;
      alu_src_r   <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      reg_write_r <= 1'b0;
    end else if (flush || (!accept_s && out_ready)) begin
      valid_r     <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      reg_write_r <= 1'b0;
    end else if (accept_s) begin
      valid_r     <= 1'b1;
      pc_r        <= in_pc;
      op1_r       <= op1_s;
      op2_r       <= op2_s;
      imm_r       <= in_imm;
      rd_r        <= in_rd;
      alu_op_r    <= in_alu_op;
      alu_src_r   <= in_alu_src;
      mem_read_r  <= in_mem_read;
      mem_write_r <= in_mem_write;
      reg_write_r <= in_reg_write;
    end else begin
      valid_r     <= valid_r;
    end
  end

  // Saturating count of load-use bubbles actually inserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'd0;
    end else if (!flush && hazard_s && out_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign in_ready      = ready_s;
  assign out_valid     = valid_r;
  assign out_pc        = pc_r;
  assign out_op1       = op1_r;
  assign out_op2       = op2_r;
  assign out_imm       = imm_r;
  assign out_rd        = rd_r;
  assign out_alu_op    = alu_op_r;
  assign out_alu_src   = alu_src_r;
  assign out_mem_read  = mem_read_r;
  assign out_mem_write = mem_write_r;
  assign out_reg_write = reg_write_r;
  assign stall_count   = stall_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: bypass, x0, load-use, backpressure, flush
// and asynchronous reset, checked against hand-computed values.
module tb_id_ex_stage;

  logic        clk, rst_n, in_valid, in_ready;
  logic [31:0] in_pc, in_imm, rf_data1, rf_data2, wb_data;
  logic [4:0]  in_rs1, in_rs2, in_rd, wb_rd;
  logic [3:0]  in_alu_op;
  logic        in_alu_src, in_mem_read, in_mem_write, in_reg_write;
  logic        wb_regwrite, flush, out_ready, out_valid;
  logic [31:0] out_pc, out_op1, out_op2, out_imm;
  logic [4:0]  out_rd;
  logic [3:0]  out_alu_op;
  logic        out_alu_src, out_mem_read, out_mem_write, out_reg_write;
  logic [15:0] stall_count;

  int vectors = 0;
  int errs    = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_alu_op(in_alu_op), .in_alu_src(in_alu_src),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_reg_write(in_reg_write), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
    .out_rd(out_rd), .out_alu_op(out_alu_op), .out_alu_src(out_alu_src),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_reg_write(out_reg_write), .stall_count(stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [31:0] imm, input logic mr,
                           input logic rw, input logic [31:0] d1, input logic [31:0] d2);
    in_valid = 1'b1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_imm = imm;
    in_alu_op = 4'h2; in_alu_src = 1'b1; in_mem_read = mr; in_mem_write = 1'b0;
    in_reg_write = rw; rf_data1 = d1; rf_data2 = d2;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    set_instr(32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    in_valid = 1'b0;
    step(); step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall", {16'd0, stall_count}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);

    // Bypass: wb to x5 overrides the stale register-file value
    rst_n = 1'b1;
    set_instr(32'h100, 5'd5, 5'd0, 5'd7, 32'h10, 1'b0, 1'b1, 32'h11, 32'hDEAD);
    wb_regwrite = 1'b1; wb_rd = 5'd5; wb_data = 32'hAA;
    #1;
    chk("a_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("a_valid", {31'd0, out_valid}, 32'd1);
    chk("a_op1_bypass", out_op1, 32'hAA);
    chk("a_op2_x0", out_op2, 32'd0);
    chk("a_pc", out_pc, 32'h100);
    chk("a_rd", {27'd0, out_rd}, 32'd7);
    chk("a_imm", out_imm, 32'h10);
    chk("a_regwrite", {31'd0, out_reg_write}, 32'd1);

    // x0 with a writeback aimed at x0
    set_instr(32'h104, 5'd6, 5'd0, 5'd8, 32'h20, 1'b0, 1'b1, 32'h66, 32'hDEAD);
    wb_regwrite = 1'b1; wb_rd = 5'd0; wb_data = 32'hBEEF;
    step();
    chk("b_op1_rf", out_op1, 32'h66);
    chk("b_op2_x0", out_op2, 32'd0);

    // Load x3, then a dependent instruction reading x3
    wb_regwrite = 1'b0;
    set_instr(32'h108, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1, 1'b1, 32'h1, 32'h2);
    step();
    chk("c_mem_read", {31'd0, out_mem_read}, 32'd1);
    set_instr(32'h10C, 5'd3, 5'd4, 5'd8, 32'h0, 1'b0, 1'b1, 32'h33, 32'h44);
    #1;
    chk("lu_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("lu_bubble_valid", {31'd0, out_valid}, 32'd0);
    chk("lu_bubble_mem_read", {31'd0, out_mem_read}, 32'd0);
    chk("lu_stall_count", {16'd0, stall_count}, 32'd1);
    chk("lu_ready_after", {31'd0, in_ready}, 32'd1);
    step();
    chk("lu_accept_valid", {31'd0, out_valid}, 32'd1);
    chk("lu_accept_pc", out_pc, 32'h10C);
    chk("lu_accept_op1", out_op1, 32'h33);
    chk("lu_stall_hold", {16'd0, stall_count}, 32'd1);

    // Backpressure for three cycles
    out_ready = 1'b0;
    set_instr(32'h110, 5'd1, 5'd2, 5'd9, 32'h0, 1'b1, 1'b1, 32'h5, 32'h6);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk("bp_out_pc", out_pc, 32'h10C);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_pc", out_pc, 32'h110);

    // Flush while a load-use hazard is also present
    flush = 1'b1;
    set_instr(32'h114, 5'd9, 5'd0, 5'd10, 32'h0, 1'b0, 1'b1, 32'h7, 32'h8);
    #1;
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_regwrite", {31'd0, out_reg_write}, 32'd0);
    chk("fl_stall_count", {16'd0, stall_count}, 32'd1);

    // Reset mid-stream, observed before any clock edge
    flush = 1'b0;
    set_instr(32'h118, 5'd2, 5'd0, 5'd4, 32'h0, 1'b0, 1'b1, 32'h9, 32'h0);
    step();
    chk("g_pc", out_pc, 32'h118);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_stall", {16'd0, stall_count}, 32'd0);
    chk("mid_rst_pc", out_pc, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    set_instr(32'h11C, 5'd2, 5'd0, 5'd4, 32'h0, 1'b0, 1'b1, 32'h9, 32'h0);
    step();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_pc", out_pc, 32'h11C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 SHALL have upstream ports: in_valid  input  1  decoded instruction present; in_ready  output  1  stage accepts this cycle.
REQ-003 SHALL have decode ports: in_pc  input  32; in_rs1/in_rs2/in_rd  input  5 each; in_imm  input  32; in_alu_op  input  4; in_alu_src, in_mem_read, in_mem_write, in_reg_write  input  1 each.
REQ-004 SHALL have register-file ports: rf_data1/rf_data2  input  32  combinational read data for in_rs1/in_rs2.
REQ-005 SHALL have writeback ports: wb_regwrite  input  1; wb_rd  input  5; wb_data  input  32; these are the same values driving the register-file write port.
REQ-006 SHALL have control ports: flush  input  1  discard stage contents; out_ready  input  1  EX accepts.
REQ-007 SHALL have outputs: out_valid  1; out_pc, out_op1, out_op2, out_imm  32 each; out_rd  5; out_alu_op  4; out_alu_src, out_mem_read, out_mem_write, out_reg_write  1 each; stall_count  16  load-use bubble count.

Function
REQ-008 SHALL hold one instruction in an output register; accept = in_valid && in_ready, sampled at rising clk.
REQ-009 SHALL drive in_ready = (!out_valid || out_ready) && !hazard, or 1 when flush is high.
REQ-010 SHALL define hazard = out_valid && out_mem_read && out_rd != 0 && in_valid && (in_rs1 == out_rd || in_rs2 == out_rd).
REQ-011 SHALL select operand A: 0 if in_rs1 == 0; else wb_data if wb_regwrite && wb_rd == in_rs1; else rf_data1; operand B likewise with in_rs2/rf_data2.
REQ-012 SHALL apply the x0 rule before the bypass rule: wb_rd == 0 never bypasses.
REQ-013 SHALL, on accept without flush, load all out_* fields from the inputs and selected operands and set out_valid = 1 at the same edge (latency 1 cycle).
REQ-014 SHALL, when out_valid && out_ready && no accept, clear out_valid at the next edge (bubble); payload fields may keep stale values.
REQ-015 SHALL, when out_valid && !out_ready, hold every out_* field stable.
REQ-016 SHALL, under hazard with out_ready = 1, emit exactly one bubble cycle, then accept the dependent instruction the following cycle.
REQ-017 SHALL increment stall_count by 1 at every edge where hazard && out_ready is high; it saturates at 16'hFFFF.
REQ-018 SHALL, when flush is high, clear out_valid at the next edge, discard the upstream instruction presented that cycle, and not update stall_count; flush overrides hazard and out_ready.
REQ-019 SHALL force out_reg_write, out_mem_read and out_mem_write to 0 whenever out_valid is 0.

Reset
REQ-020 SHALL, on rst_n low, asynchronously clear out_valid, every out_* field and stall_count to 0.
REQ-021 SHALL drive in_ready = 0 while rst_n is low; the first accept occurs at the first rising clk with rst_n high.
REQ-022 SHALL discard any in-flight instruction on reset mid-operation; no partial state survives.

Verification
REQ-023 SHALL pass bypass: in_rs1=5, rf_data1=0x11, wb_regwrite=1, wb_rd=5, wb_data=0xAA -> out_op1=0xAA next cycle.
REQ-024 SHALL pass x0: in_rs2=0, rf_data2=0xDEAD, wb_rd=0, wb_regwrite=1 -> out_op2=0.
REQ-025 SHALL pass load-use: out holds lw with out_rd=3, incoming in_rs1=3, out_ready=1 -> in_ready=0, out_valid=0 for one cycle, stall_count=1, accept next cycle.
REQ-026 SHALL pass backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0 and out_pc unchanged throughout.
REQ-027 SHALL pass flush: flush=1 with in_valid=1 -> in_ready=1, out_valid=0 next cycle, out_reg_write=0.
REQ-028 SHALL pass reset: rst_n low mid-stream -> out_valid=0, stall_count=0 immediately, without a clock edge.
